// File: rtl/pwm_dac_pkg.sv
// Shared constants for the function generator output path.
// Mode encodings and default DAC sample width.
package pwm_dac_pkg;

  localparam int DAC_WIDTH = 8;

  localparam logic MODE_PWM = 1'b0;
  localparam logic MODE_SD  = 1'b1;

endpackage

// File: rtl/tick_gen.sv
// Modulator tick prescaler: one-cycle tick every PRESCALE clocks.
// PRESCALE=1 degenerates to a tick on every cycle.
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] r_pre;
  logic          w_last;

  assign w_last = (r_pre == LAST);
  assign tick   = w_last;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pre <= '0;
    end else if (w_last) begin
      r_pre <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
    end
  end

endmodule

// File: rtl/pwm_dac.sv
// 1-bit DAC driver: double-buffered sample intake feeding a
// fixed-frame PWM or first-order sigma-delta modulator.
module pwm_dac
  import pwm_dac_pkg::*;
#(
  parameter int WIDTH    = DAC_WIDTH,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sample,
  input  logic             sample_valid,
  output logic             sample_ready,
  input  logic             mode,
  input  logic             clr_underrun,
  output logic             dac_out,
  output logic             frame_start,
  output logic             underrun
);

  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] r_duty;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_full;
  logic             r_mode_q;
  logic             r_dac;
  logic             r_fs;
  logic             r_underrun;

  logic             w_tick;
  logic             w_boundary;
  logic             w_accept;
  logic             w_pwm;
  logic [WIDTH:0]   w_sum;

  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (w_tick)
  );

  assign w_boundary = w_tick && (r_cnt == '1);
  assign w_accept   = sample_valid && !r_hold_full;
  assign w_pwm      = (r_cnt < r_duty);
  assign w_sum      = {1'b0, r_acc} + {1'b0, r_duty};

  assign sample_ready = ~r_hold_full;
  assign dac_out      = r_dac;
  assign frame_start  = r_fs;
  assign underrun     = r_underrun;

  // Intake buffer: a boundary only consumes a full holding register,
  // and acceptance needs it empty, so the two never collide.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hold      <= '0;
      r_hold_full <= 1'b0;
      r_duty      <= '0;
    end else if (w_boundary && r_hold_full) begin
      r_duty      <= r_hold;
      r_hold_full <= 1'b0;
    end else if (w_accept) begin
      r_hold      <= sample;
      r_hold_full <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_dac    <= 1'b0;
      r_mode_q <= MODE_PWM;
    end else if (w_tick) begin
      r_cnt <= r_cnt + 1'b1;
      if (r_mode_q == MODE_SD) begin
        r_dac <= w_sum[WIDTH];
      end else begin
        r_dac <= w_pwm;
      end
      if (w_boundary) begin
        r_acc    <= '0;
        r_mode_q <= mode;
      end else begin
        r_acc <= w_sum[WIDTH-1:0];
      end
    end
  end

  // A fresh underrun event takes priority over a clear request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fs       <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_fs <= w_boundary;
      if (w_boundary && !r_hold_full) begin
        r_underrun <= 1'b1;
      end else if (clr_underrun) begin
        r_underrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/pwm_dac.md
# pwm_dac

Downstream stage of the function generator. Accepts the generator's 8-bit sample stream through a valid/ready handshake and converts it to a 1-bit DAC drive for the external RC filter, using either fixed-frame PWM or first-order sigma-delta modulation. Double-buffers one sample so the generator can run ahead by one frame. Flags underruns when no new sample is available at a frame boundary.

## Interface
- WIDTH, 8, sample width; frame length is 2^WIDTH ticks
- PRESCALE, 1, clocks per modulator tick (≥1)

- clk  in  1  system clock, rising edge
- rst  in  1  reset; one clock; reset is asynchronous and active-low
- sample  in  WIDTH  unsigned sample from function generator
- sample_valid  in  1  sample is presented
- sample_ready  out  1  holding register empty; transfer on valid&&ready
- mode  in  1  0 = PWM, 1 = sigma-delta; sampled at frame boundary only
- clr_underrun  in  1  clears sticky underrun flag
- dac_out  out  1  registered 1-bit DAC drive
- frame_start  out  1  one-cycle pulse, first tick of each frame
- underrun  out  1  sticky: a frame boundary found the holding register empty

## Operation
- Reset (rst=0, async): prescaler, cnt, duty, acc, hold, hold_full, mode_q, dac_out, frame_start, underrun all 0; sample_ready=1.
- Handshake: sample_ready = ~hold_full (combinational from register). On valid&&ready: hold<=sample, hold_full<=1. Valid is ignored while ready=0; no combinational valid→ready path.
- Tick: prescaler counts 0..PRESCALE-1; tick asserted when prescaler = PRESCALE-1. PRESCALE=1 → tick every cycle.
- Frame counter cnt (WIDTH bits) increments on tick, wraps 2^WIDTH-1 → 0.
- Frame boundary = tick && cnt = 2^WIDTH-1. At boundary:
  - hold_full=1: duty<=hold, hold_full<=0.
  - hold_full=0: duty unchanged (last sample repeats), underrun<=1.
  - mode_q<=mode; acc<=0.
- Boundary and acceptance in the same cycle: boundary sees pre-cycle hold_full (0), so underrun sets, and the accepted sample lands in hold for the next frame.
- frame_start registered: high for one cycle, the cycle after the boundary (cnt=0 with new duty).
- clr_underrun clears underrun; a simultaneous new underrun event wins (flag stays 1).
- PWM (mode_q=0): on each tick dac_out <= (cnt < duty), evaluated on pre-tick values. duty=0 → constant 0; duty=2^WIDTH-1 → high 255 of 256 ticks.
- Sigma-delta (mode_q=1): acc is WIDTH+1 bits; on each tick {carry, acc[WIDTH-1:0]} <= acc[WIDTH-1:0] + duty; dac_out <= carry. Ones density = duty/2^WIDTH.
- Between ticks all modulator state and dac_out hold.

## Timing
- Sample-to-output latency: a sample accepted in frame N drives frame N+1 (≤ 2^WIDTH·PRESCALE + 1 cycles after acceptance).
- dac_out is one cycle behind the cnt/duty state that produced it.
- Ready re-asserts the cycle after a boundary that consumed hold.
- Mid-operation reset: everything returns to reset values immediately; first post-reset frame outputs duty=0 (dac_out=0) and its boundary sets underrun unless a sample was accepted.
- Mode change mid-frame: no effect until next boundary.

## Structure
- Shared package: MODE_PWM=1'b0, MODE_SD=1'b1, default DAC_WIDTH=8; the function generator uses the same width constant.
- One sub-module: tick_gen (prescaler, parameter PRESCALE, outputs tick). Frame counter, buffer, and modulators stay in pwm_dac.

## Test plan
- Reset mid-frame: assert rst at cnt=100 with duty=200 → dac_out, frame_start, underrun go 0 at once; sample_ready=1; cnt restarts at 0 after release.
- PWM duty 64, PRESCALE=1, mode=0: feed 64 each frame → exactly 64 high cycles per 256-cycle frame, contiguous from frame start (+1 cycle latency); underrun stays 0.
- Extremes: samples 0 then 255 → 0 high cycles, then 255 high in the next frame; frame_start period 256 cycles.
- Backpressure/underrun: send two samples (10, 20) back-to-back → second stalls with ready=0 until the boundary; withhold the third → duty 20 repeats, underrun=1 at boundary; clr_underrun in a later cycle → 0; clr_underrun on a boundary cycle with empty hold → stays 1.
- Sigma-delta 128, mode=1: dac_out toggles 0,1,0,1…, 128 ones per frame; sample 1 → exactly one 1 per frame.
- PRESCALE=4, PWM duty 3: frame = 1024 cycles, dac_out high 12 cycles; mode toggled mid-frame takes effect only at the next frame_start.
